seq_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator. It is the successor to the team's fixed 4-bit combinational comparator.
- Accepts two WIDTH-bit operands through a valid/ready handshake and compares them CHUNK_W bits per cycle, starting at the most significant chunk.
- Supports per-transaction signed or unsigned mode.
- Returns a one-hot less/equal/greater result through a valid/ready output handshake. Used wherever wide operands would break timing in a single-cycle compare.

---
 rtl/seq_comparator_pkg.sv | 41 ++++
 rtl/seq_comparator_chunk.sv | 15 +
 rtl/seq_comparator.sv | 168 ++++++++++++++++
 tb/tb_seq_comparator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_comparator_pkg.sv
// Shared types for seq_comparator: controller states and the 2-bit result code
// that is decoded into the one-hot less/equal/greater outputs.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] res_t;

  localparam res_t RES_EQ = 2'b00;
  localparam res_t RES_LT = 2'b01;
  localparam res_t RES_GT = 2'b10;

  // One-hot {greater, equal, less}; the unused code falls back to equal.
  function automatic logic [2:0] res_decode(input res_t r);
    logic [2:0] oh;
    case (r)
      RES_LT:  oh = 3'b001;
      RES_EQ:  oh = 3'b010;
      RES_GT:  oh = 3'b100;
      default: oh = 3'b010;
    endcase
    return oh;
  endfunction

  function automatic res_t res_from_chunk(input logic lt, input logic gt);
    res_t r;
    if (gt) begin
      r = RES_GT;
    end else if (lt) begin
      r = RES_LT;
    end else begin
      r = RES_EQ;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_comparator_chunk.sv
// comparator_chunk: combinational CHUNK_W-bit unsigned magnitude compare,
// the per-cycle slice used by seq_comparator.
module comparator_chunk #(
  parameter int CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic               lt,
  output logic               gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle WIDTH-bit magnitude compare, CHUNK_W bits per cycle,
// MSB chunk first. Optional macro SEQ_COMPARATOR_EARLY_EXIT_EN ends on first difference.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CHUNK_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] DinA,
  input  logic [WIDTH-1:0] DinB,
  input  logic             is_signed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  res_t             res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             greater_q, greater_d;

  logic [CHUNK_W-1:0] chunk_a;
  logic [CHUNK_W-1:0] chunk_b;
  logic               chunk_lt;
  logic               chunk_gt;
  logic               chunk_diff;
  logic [WIDTH-1:0]   sign_flip;

  assign chunk_a    = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
  assign chunk_b    = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
  assign chunk_diff = chunk_lt | chunk_gt;
  // Flipping both MSBs maps two's-complement order onto unsigned order.
  assign sign_flip  = {is_signed, {(WIDTH-1){1'b0}}};

  comparator_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
    .lt (chunk_lt),
    .gt (chunk_gt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    res_d     = res_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = DinA ^ sign_flip;
          b_d       = DinB ^ sign_flip;
          idx_d     = IDX_LAST;
          decided_d = 1'b0;
          res_d     = RES_EQ;
          state_d   = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (!decided_q && chunk_diff) begin
          decided_d = 1'b1;
          res_d     = res_from_chunk(chunk_lt, chunk_gt);
        end else begin
          decided_d = decided_q;
        end
        if (idx_q == IDX_ZERO) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
          if (!decided_q && chunk_diff) begin
            state_d = DONE;
          end else begin
            state_d = CMP;
          end
`else
          state_d = CMP;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    if (out_valid_d) begin
      {greater_d, equal_d, less_d} = res_decode(res_d);
    end else begin
      {greater_d, equal_d, less_d} = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= IDX_ZERO;
      decided_q   <= 1'b0;
      res_q       <= RES_EQ;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      decided_q   <= decided_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      less_q      <= less_d;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign less      = less_q;
  assign equal     = equal_q;
  assign greater   = greater_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator (WIDTH=16, CHUNK_W=4): directed plan cases
// plus random pairs against an arithmetic reference model.
module tb_seq_comparator;

  localparam int WIDTH   = 16;
  localparam int CHUNK_W = 4;
  localparam int NCHUNK  = WIDTH / CHUNK_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] DinA;
  logic [WIDTH-1:0] DinB;
  logic             is_signed;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             less;
  logic             equal;
  logic             greater;
  logic             busy;

  int errors = 0;
  int checks = 0;

  seq_comparator #(
    .WIDTH   (WIDTH),
    .CHUNK_W (CHUNK_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .DinA      (DinA),
    .DinB      (DinB),
    .is_signed (is_signed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .less      (less),
    .equal     (equal),
    .greater   (greater),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {greater, equal, less} from plain signed/unsigned arithmetic.
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic s);
    logic lt;
    logic gt;
    if (s) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    return {gt, (a == b), lt};
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    int top;
    d = a ^ b;
    top = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) top = i;
    end
    if (top < 0) return NCHUNK;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    return NCHUNK - top / CHUNK_W;
`else
    return NCHUNK;
`endif
  endfunction

  task automatic do_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                        input int hold);
    logic [2:0] er;
    int el;
    int lat;
    er = model_res(a, b, s);
    el = model_lat(a, b);
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    DinA = a; DinB = b; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    DinA = WIDTH'($urandom); DinB = WIDTH'($urandom); is_signed = 1'($urandom);
    chk("busy_after_accept", 32'({busy, in_ready}), 32'h2);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("result", 32'({greater, equal, less}), 32'(er));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold", 32'({out_valid, in_ready, busy, greater, equal, less}), 32'({3'b101, er}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", 32'({out_valid, busy, in_ready, greater, equal, less}), 32'h08);
  endtask

  logic [WIDTH-1:0] pa [3];
  logic [WIDTH-1:0] pb [3];
  logic             ps [3];
  logic [2:0]       exp_q [$];
  int sent;
  int got;
  int cyc;
  int extra;

  initial begin
    rst_n = 1'b0; DinA = '0; DinB = '0; is_signed = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({out_valid, busy, greater, equal, less}), 32'h0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed cases from the test plan.
    do_txn(16'h1234, 16'h1235, 1'b0, 0);
    do_txn(16'h9000, 16'h1FFF, 1'b0, 1);
    do_txn(16'hFFFF, 16'h0001, 1'b1, 0);
    do_txn(16'hFFFF, 16'h0001, 1'b0, 0);
    do_txn(16'h8000, 16'h7FFF, 1'b1, 0);
    do_txn(16'h8000, 16'h7FFF, 1'b0, 0);
    do_txn(16'hABCD, 16'hABCD, 1'b0, 10);
    do_txn(16'hABCD, 16'hABCD, 1'b1, 0);

    // Back-to-back with in_valid held high and out_ready high.
    pa[0] = 16'h0F00; pb[0] = 16'h0E00; ps[0] = 1'b0;
    pa[1] = 16'h8001; pb[1] = 16'h0001; ps[1] = 1'b1;
    pa[2] = 16'h5555; pb[2] = 16'h5555; ps[2] = 1'b0;
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          chk("b2b_result", 32'({greater, equal, less}), 32'(exp_q.pop_front()));
        end else begin
          chk("b2b_unexpected", 32'd1, 32'd0);
        end
        got++;
      end
      if (in_ready && sent < 3) begin
        DinA = pa[sent]; DinB = pb[sent]; is_signed = ps[sent]; in_valid = 1'b1;
        exp_q.push_back(model_res(pa[sent], pb[sent], ps[sent]));
        sent++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        DinA = WIDTH'($urandom); DinB = WIDTH'($urandom); is_signed = 1'($urandom);
        in_valid = (sent < 3) ? 1'b1 : in_valid;
      end
    end
    in_valid = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("b2b_count", 32'(got), 32'd3);
    chk("b2b_no_dup", 32'(extra), 32'd0);
    out_ready = 1'b0;

    // Reset during CMP discards the transaction.
    @(negedge clk);
    DinA = 16'h1234; DinB = 16'h4321; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_outputs", 32'({out_valid, busy, greater, equal, less}), 32'h0);
    chk("midreset_ready", 32'(in_ready), 32'd1);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midreset_no_result", 32'(extra), 32'd0);
    do_txn(16'h4321, 16'h1234, 1'b0, 0);

    // Random pairs; bias some toward shared upper chunks to vary the first difference.
    for (int n = 0; n < 24; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = {ra[15:4], rb[3:0]};
        2:       rb = {ra[15:8], rb[7:0]};
        default: rb = rb;
      endcase
      do_txn(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
